board_drop_writer: RTL and testbench

//  Owns the Connect-4 board register array and places tokens into it under gravity.

---
 rtl/board_drop_writer.sv | 150 +++++++++++++++
 tb/tb_board_drop_writer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_drop_writer.sv
// Connect-4 board owner: accepts one move per handshake and scans the column bottom-up
// for the lowest empty cell. It writes the token there, pulses check_en, then reports the move.
module board_drop_writer #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             move_valid,
  input  logic [2:0]                       move_col,
  input  logic [1:0]                       move_player,
  output logic                             move_ready,
  output logic [ROWS-1:0][COLS-1:0][1:0]   board,
  output logic                             check_en,
  output logic                             move_done,
  output logic                             move_ok,
  output logic [1:0]                       move_err,
  output logic [2:0]                       placed_row,
  output logic [5:0]                       token_count,
  output logic                             board_full
);

  localparam logic [2:0] COLS_W   = 3'(COLS);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [5:0] TOK_MAX  = 6'(ROWS * COLS);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_COL  = 2'b01;
  localparam logic [1:0] ERR_FULL = 2'b10;
  localparam logic [1:0] ERR_PLY  = 2'b11;

  typedef enum logic [2:0] {IDLE, SCAN, WRITE, CHECK, REPORT} state_t;

  state_t     state_reg;
  logic [2:0] col_reg;
  logic [1:0] player_reg;
  logic [2:0] row_ptr_reg;
  logic [2:0] row_tgt_reg;
  logic [1:0] err_pend_reg;

  logic [1:0] cell_reg [ROWS][COLS];

  logic scan_empty;
  logic tgt_empty;

  assign scan_empty = (cell_reg[row_ptr_reg][col_reg] == 2'b00);
  assign tgt_empty  = (cell_reg[row_tgt_reg][col_reg] == 2'b00);

  // Clear blocks acceptance in the same cycle so a wiped board never sees that move.
  assign move_ready = (state_reg == IDLE) && rst_n && !clear;
  assign board_full = (token_count == TOK_MAX);

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic wr_hit;

      assign wr_hit = (state_reg == WRITE) && (row_tgt_reg == 3'(gi)) &&
                      (col_reg == 3'(gj)) && (cell_reg[gi][gj] == 2'b00);
      assign board[gi][gj] = cell_reg[gi][gj];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cell_reg[gi][gj] <= 2'b00;
        end else if (clear) begin
          cell_reg[gi][gj] <= 2'b00;
        end else if (wr_hit) begin
          cell_reg[gi][gj] <= player_reg;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      col_reg      <= 3'd0;
      player_reg   <= 2'b00;
      row_ptr_reg  <= 3'd0;
      row_tgt_reg  <= 3'd0;
      err_pend_reg <= ERR_NONE;
      token_count  <= 6'd0;
      check_en     <= 1'b0;
      move_done    <= 1'b0;
      move_ok      <= 1'b0;
      move_err     <= ERR_NONE;
      placed_row   <= 3'd0;
    end else if (clear) begin
      // Abort: status of the last reported move is left intact.
      state_reg   <= IDLE;
      token_count <= 6'd0;
      check_en    <= 1'b0;
      move_done   <= 1'b0;
    end else begin
      check_en  <= 1'b0;
      move_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (move_valid) begin
            col_reg    <= move_col;
            player_reg <= move_player;
            if (move_col >= COLS_W) begin
              err_pend_reg <= ERR_COL;
              state_reg    <= REPORT;
            end else if (move_player == 2'b00 || move_player == 2'b11) begin
              err_pend_reg <= ERR_PLY;
              state_reg    <= REPORT;
            end else begin
              err_pend_reg <= ERR_NONE;
              row_ptr_reg  <= LAST_ROW;
              state_reg    <= SCAN;
            end
          end
        end
        SCAN: begin
          if (scan_empty) begin
            row_tgt_reg <= row_ptr_reg;
            state_reg   <= WRITE;
          end else if (row_ptr_reg == 3'd0) begin
            err_pend_reg <= ERR_FULL;
            state_reg    <= REPORT;
          end else begin
            row_ptr_reg <= row_ptr_reg - 3'd1;
          end
        end
        WRITE: begin
          if (tgt_empty && token_count != TOK_MAX) begin
            token_count <= token_count + 6'd1;
          end
          state_reg <= CHECK;
        end
        CHECK: begin
          check_en  <= 1'b1;
          state_reg <= REPORT;
        end
        REPORT: begin
          move_done <= 1'b1;
          move_ok   <= (err_pend_reg == ERR_NONE);
          move_err  <= err_pend_reg;
          if (err_pend_reg == ERR_NONE) begin
            placed_row <= row_tgt_reg;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_drop_writer.sv
// Directed bench for board_drop_writer: a move table plus clear, reset and full-board sequences.
module tb_board_drop_writer;

  logic                  clk;
  logic                  rst_n;
  logic                  clear;
  logic                  move_valid;
  logic [2:0]            move_col;
  logic [1:0]            move_player;
  logic                  move_ready;
  logic [5:0][6:0][1:0]  board;
  logic                  check_en;
  logic                  move_done;
  logic                  move_ok;
  logic [1:0]            move_err;
  logic [2:0]            placed_row;
  logic [5:0]            token_count;
  logic                  board_full;

  board_drop_writer #(.ROWS(6), .COLS(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .move_valid  (move_valid),
    .move_col    (move_col),
    .move_player (move_player),
    .move_ready  (move_ready),
    .board       (board),
    .check_en    (check_en),
    .move_done   (move_done),
    .move_ok     (move_ok),
    .move_err    (move_err),
    .placed_row  (placed_row),
    .token_count (token_count),
    .board_full  (board_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] col;
    logic [1:0] player;
    logic       ok;
    logic [1:0] err;
    logic [2:0] row;
    int         lat;
  } vec_t;

  vec_t vecs [11];

  int n_cmp;
  int n_miss;
  logic [5:0][6:0][1:0] model_b;
  int model_cnt;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_wipe();
    model_b   = '0;
    model_cnt = 0;
  endtask

  task automatic do_move(input logic [2:0] c, input logic [1:0] p, input logic eok,
                         input logic [1:0] eerr, input logic [2:0] erow, input int elat,
                         input string tag);
    int done_cyc;
    int chk_cyc;
    int chk_pulses;
    logic got_ok;
    logic [1:0] got_err;
    logic [2:0] got_row;
    done_cyc   = -1;
    chk_cyc    = -1;
    chk_pulses = 0;
    got_ok     = 1'b0;
    got_err    = 2'b00;
    got_row    = 3'd0;
    @(negedge clk);
    chk({tag, " ready"}, 96'(move_ready), 96'd1);
    move_valid  = 1'b1;
    move_col    = c;
    move_player = p;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    for (int n = 1; n <= 20 && done_cyc < 0; n++) begin
      @(posedge clk);
      #1;
      if (check_en) begin
        chk_pulses++;
        if (chk_cyc < 0) chk_cyc = n;
      end
      if (move_done) begin
        done_cyc = n;
        got_ok   = move_ok;
        got_err  = move_err;
        got_row  = placed_row;
      end
    end
    if (eok) begin
      model_b[erow][c] = p;
      model_cnt++;
    end
    chk({tag, " done_lat"}, 96'(done_cyc), 96'(elat));
    chk({tag, " ok"}, 96'(got_ok), 96'(eok));
    chk({tag, " err"}, 96'(got_err), 96'(eerr));
    if (eok) begin
      chk({tag, " row"}, 96'(got_row), 96'(erow));
      chk({tag, " check_lat"}, 96'(chk_cyc), 96'(elat - 1));
    end
    chk({tag, " check_pulses"}, 96'(chk_pulses), 96'(eok ? 1 : 0));
    chk({tag, " board"}, 96'(board), 96'(model_b));
    chk({tag, " count"}, 96'(token_count), 96'(model_cnt));
    chk({tag, " full"}, 96'(board_full), 96'(model_cnt == 42));
    $display("move %s col=%0d player=%0d done@%0d ok=%0b err=%0b row=%0d count=%0d",
             tag, c, p, done_cyc, got_ok, got_err, got_row, token_count);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (move_done || check_en) pulses++;
    end
    chk({tag, " no_pulse"}, 96'(pulses), 96'd0);
  endtask

  initial begin
    n_cmp       = 0;
    n_miss      = 0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    move_valid  = 1'b0;
    move_col    = 3'd0;
    move_player = 2'b00;
    model_wipe();

    vecs[0]  = '{3'd3, 2'b01, 1'b1, 2'b00, 3'd5, 4};
    vecs[1]  = '{3'd0, 2'b01, 1'b1, 2'b00, 3'd5, 4};
    vecs[2]  = '{3'd0, 2'b10, 1'b1, 2'b00, 3'd4, 5};
    vecs[3]  = '{3'd0, 2'b01, 1'b1, 2'b00, 3'd3, 6};
    vecs[4]  = '{3'd0, 2'b10, 1'b1, 2'b00, 3'd2, 7};
    vecs[5]  = '{3'd0, 2'b01, 1'b1, 2'b00, 3'd1, 8};
    vecs[6]  = '{3'd0, 2'b10, 1'b1, 2'b00, 3'd0, 9};
    vecs[7]  = '{3'd0, 2'b01, 1'b0, 2'b10, 3'd0, 7};
    vecs[8]  = '{3'd7, 2'b11, 1'b0, 2'b01, 3'd0, 1};
    vecs[9]  = '{3'd2, 2'b00, 1'b0, 2'b11, 3'd0, 1};
    vecs[10] = '{3'd3, 2'b10, 1'b1, 2'b00, 3'd4, 5};

    // Reset state
    #1;
    chk("rst ready_low", 96'(move_ready), 96'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst ready", 96'(move_ready), 96'd1);
    chk("rst board", 96'(board), 96'd0);
    chk("rst count", 96'(token_count), 96'd0);
    chk("rst status", 96'({check_en, move_done, move_ok, move_err, placed_row, board_full}), 96'd0);
    $display("reset released: ready=%0b count=%0d", move_ready, token_count);

    // Move table
    for (int i = 0; i < 11; i++) begin
      do_move(vecs[i].col, vecs[i].player, vecs[i].ok, vecs[i].err, vecs[i].row,
              vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Clear during SCAN of the filled column 0
    @(negedge clk);
    move_valid  = 1'b1;
    move_col    = 3'd0;
    move_player = 2'b01;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    #1;
    model_wipe();
    chk("clr ready", 96'(move_ready), 96'd1);
    chk("clr board", 96'(board), 96'd0);
    chk("clr count", 96'(token_count), 96'd0);
    watch_idle("clr", 10);
    $display("clear during scan: count=%0d ready=%0b", token_count, move_ready);

    // Clear together with a move request in IDLE
    @(negedge clk);
    clear       = 1'b1;
    move_valid  = 1'b1;
    move_col    = 3'd1;
    move_player = 2'b01;
    #1;
    chk("clrmv ready", 96'(move_ready), 96'd0);
    @(posedge clk);
    @(negedge clk);
    clear      = 1'b0;
    move_valid = 1'b0;
    watch_idle("clrmv", 10);
    chk("clrmv board", 96'(board), 96'd0);
    $display("clear with move: board=%0h", board);

    // Asynchronous reset in the middle of WRITE
    @(negedge clk);
    move_valid  = 1'b1;
    move_col    = 3'd4;
    move_player = 2'b01;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst board", 96'(board), 96'd0);
    chk("arst count", 96'(token_count), 96'd0);
    chk("arst status", 96'({check_en, move_done, move_ok, move_err, placed_row}), 96'd0);
    chk("arst ready", 96'(move_ready), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst ready_after", 96'(move_ready), 96'd1);
    watch_idle("arst", 4);
    chk("arst board_after", 96'(board), 96'd0);
    $display("async reset mid-write: board=%0h count=%0d", board, token_count);

    // Fill all 42 cells
    for (int c = 0; c < 7; c++) begin
      for (int k = 0; k < 6; k++) begin
        do_move(3'(c), (k % 2 == 1) ? 2'b10 : 2'b01, 1'b1, 2'b00, 3'(5 - k), 4 + k,
                $sformatf("fill_c%0d_k%0d", c, k));
      end
    end
    chk("full flag", 96'(board_full), 96'd1);
    chk("full count", 96'(token_count), 96'd42);
    do_move(3'd5, 2'b01, 1'b0, 2'b10, 3'd0, 7, "onfull");
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    #1;
    model_wipe();
    chk("unfull flag", 96'(board_full), 96'd0);
    chk("unfull count", 96'(token_count), 96'd0);
    chk("unfull board", 96'(board), 96'd0);
    $display("full board cleared: full=%0b count=%0d", board_full, token_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
